// File: rtl/pc_fetch_unit_pkg.sv
// ============================================================================
// fetch_pkg : shared types and constants for pc_fetch_unit       Rev 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam int FETCH_XLEN = 32;

  localparam logic [FETCH_XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [FETCH_XLEN-1:0] INSTR_NOP        = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/pc_fetch_unit_if.sv
// ============================================================================
// pc_fetch_unit_if : instruction-memory and decode handshakes    Rev 1.0
// ============================================================================
`default_nettype none

interface pc_fetch_unit_if;
  import fetch_pkg::*;

  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [FETCH_XLEN-1:0] imem_req_addr;
  logic                  imem_rsp_valid;
  logic [FETCH_XLEN-1:0] imem_rsp_data;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [FETCH_XLEN-1:0] instr_data;
  logic [FETCH_XLEN-1:0] instr_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output instr_valid, instr_data, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  instr_valid, instr_data, instr_pc,
    output instr_ready
  );

endinterface

`default_nettype wire

// File: rtl/pc_fetch_unit_pc_reg.sv
// ============================================================================
// pc_reg : program counter with load enable, word alignment forced  Rev 1.0
// ============================================================================
`default_nettype none

module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [FETCH_XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  input  wire logic                  load,
  input  wire logic [FETCH_XLEN-1:2] next_word,
  output      logic [FETCH_XLEN-1:0] pc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= {next_word, 2'b00};
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// pc_fetch_unit : PC + single-outstanding fetch FSM; FETCH_PERF_CNT_EN adds
//                 perf_fetch_cnt / perf_redirect_cnt outputs       Rev 1.0
// ============================================================================
`default_nettype none

module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          XLEN     = 32
) (
  input  wire logic            clk,
  input  wire logic            reset,
  pc_fetch_unit_if.master      bus,
  input  wire logic            redirect_valid,
  input  wire logic [XLEN-1:0] redirect_pc,
  output      logic [XLEN-1:0] pc_plus4,
  output      logic            misalign_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output      logic [31:0]     perf_fetch_cnt,
  output      logic [31:0]     perf_redirect_cnt
`endif
);

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic            drop;
  logic            drop_next;
  logic            req_valid;
  logic            capture;
  logic            handshake;
  logic            redirect_take;
  logic            pc_load;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] instr_data;
  logic [XLEN-1:0] instr_pc;
  logic            misalign;

  assign pc_plus4 = pc + 32'd4;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (pc_load),
    .next_word (redirect_take ? redirect_pc[XLEN-1:2] : pc_plus4[XLEN-1:2]),
    .pc        (pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= REQ;
      drop  <= 1'b0;
    end else begin
      state <= state_next;
      drop  <= drop_next;
    end
  end

  // Redirects are sampled any time outside HOLD; in HOLD only with the handshake.
  always_comb begin
    state_next    = state;
    drop_next     = drop;
    req_valid     = 1'b0;
    capture       = 1'b0;
    handshake     = 1'b0;
    redirect_take = 1'b0;
    case (state)
      REQ: begin
        req_valid     = !reset;
        redirect_take = redirect_valid;
        if (bus.imem_req_ready && !reset) begin
          state_next = WAIT;
          drop_next  = redirect_valid;
        end
      end
      WAIT: begin
        redirect_take = redirect_valid;
        if (bus.imem_rsp_valid) begin
          if (!drop && !redirect_valid) begin
            capture    = 1'b1;
            state_next = HOLD;
          end else begin
            drop_next  = 1'b0;
            state_next = REQ;
          end
        end else if (redirect_valid) begin
          drop_next = 1'b1;
        end
      end
      HOLD: begin
        if (bus.instr_ready) begin
          handshake     = 1'b1;
          redirect_take = redirect_valid;
          state_next    = REQ;
        end
      end
      default: state_next = REQ;
    endcase
    pc_load = handshake | redirect_take;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_data <= '0;
      instr_pc   <= '0;
      misalign   <= 1'b0;
    end else begin
      if (capture) begin
        instr_data <= bus.imem_rsp_data;
        instr_pc   <= pc;
      end
      misalign <= redirect_take && (redirect_pc[1:0] != 2'b00);
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc;
  assign bus.instr_valid    = (state == HOLD);
  assign bus.instr_data     = instr_data;
  assign bus.instr_pc       = instr_pc;
  assign misalign_err       = misalign;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] redirect_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      if (handshake)     fetch_cnt    <= fetch_cnt + 32'd1;
      if (redirect_take) redirect_cnt <= redirect_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt    = fetch_cnt;
  assign perf_redirect_cnt = redirect_cnt;
`endif

endmodule

`default_nettype wire

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer for the single-cycle RISC-V core.
- Holds the architectural PC and issues one word fetch at a time to instruction memory.
- Presents PC+4 as the sequential next-PC candidate to the PC-select mux.
- Accepts the selected next PC back as a redirect, closing the PC-select loop from the producing/consuming side.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, address/data width; only 32 is supported.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- redirect_valid  input  1  next PC is a non-sequential target (PCsrc=1 path)
- redirect_pc  input  32  target address (ALUResult path)
- pc_plus4  output  32  current PC + 4, sequential candidate for the PC mux
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  32  fetch address, word aligned
- imem_rsp_valid  input  1  fetch data returned
- imem_rsp_data  input  32  instruction word
- instr_valid  output  1  instruction available to decode
- instr_ready  input  1  decode consumes instruction
- instr_data  output  32  instruction word
- instr_pc  output  32  PC of instr_data
- misalign_err  output  1  one-cycle pulse: redirect_pc[1:0] != 0

Behaviour:
- Reset (synchronous, active-high): pc=RESET_PC, state=REQ, imem_req_valid=0 in the reset cycle, instr_valid=0, instr_data=0, instr_pc=0, misalign_err=0, drop=0.
- pc_plus4 = pc + 4, combinational, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- States:
  - REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready go to WAIT.
  - WAIT: on imem_rsp_valid, if drop=0 capture data/pc into the output register and go to HOLD; if drop=1 discard, clear drop, go to REQ.
  - HOLD: instr_valid=1. On instr_ready (handshake): pc <= redirect_valid ? {redirect_pc[31:2],2'b00} : pc_plus4, then go to REQ.
- Single outstanding request; no speculative next fetch.
- Latency: minimum 3 cycles from request issue to instr_valid with zero-wait memory (REQ -> WAIT -> HOLD).
- Redirect sampling:
  - In HOLD, redirect is sampled only with the handshake.
  - In REQ or WAIT, a redirect_valid pulse updates pc immediately.
  - In WAIT, that redirect also sets drop so the stale response is discarded.
  - In REQ, the redirect takes effect before the request is accepted: imem_req_addr changes and the request is not withdrawn.
  - If the redirect coincides with imem_req_ready in REQ, the accepted address is the old pc and drop=1.
- misalign_err pulses for one cycle whenever a sampled redirect has redirect_pc[1:0] != 0; the low bits are forced to 0.
- Response arriving in the same cycle as a redirect in WAIT: the response is discarded and the state goes to REQ with the new pc.
- instr_data and instr_pc hold stable while instr_valid=1 and instr_ready=0.
- Reset mid-transaction: the state machine returns to REQ and drop is cleared. A late response arriving after reset in REQ is ignored, since responses are only consumed in WAIT.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] (increments on each instr handshake) and perf_redirect_cnt[31:0] (increments on each sampled redirect). Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters are absent; no other behaviour change.

Decomposition:
- Shared package fetch_pkg: fetch_state_t enum (REQ, WAIT, HOLD), RESET_PC_DEFAULT, INSTR_NOP = 32'h0000_0013.
- Sub-module pc_reg: PC register with load-enable and alignment force.
- FSM and output register live in the top.

Test Plan:
- Reset then zero-wait memory, instr_ready=1 -> instr_pc sequence 0x0, 0x4, 0x8, one instruction every 3 cycles; pc_plus4=0x4 after reset.
- Redirect to 0x100 during HOLD handshake -> next imem_req_addr=0x100, then instr_pc=0x100.
- Redirect to 0x200 while in WAIT, response returns the next cycle with 0xDEADBEEF -> word discarded, instr_valid stays 0, next request addr=0x200.
- Redirect to 0x103 -> misalign_err pulses once, fetch addr=0x100.
- instr_ready held low for 5 cycles in HOLD -> instr_valid, instr_data and instr_pc stable; no new imem request.
- pc=0xFFFF_FFFC sequential advance -> pc_plus4=0x0, next fetch addr=0x0; reset asserted in WAIT -> next cycle REQ with addr=RESET_PC.
